// File: rtl/bcd_to_binary.sv
// ============================================================================
// Module  : bcd_to_binary
// Brief   : Packed BCD to unsigned binary converter using reverse double-dabble.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_input,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      binary_output,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [BCD_W-1:0]   w_shift_bcd;
    logic [BCD_W-1:0]   w_next_bcd;
    logic [BIN_W-1:0]   w_next_bin;
    logic [DIGITS-1:0]  w_digit_bad;
    logic               w_in_err;

    assign w_shift_bcd = {1'b0, r_bcd[BCD_W-1:1]};
    assign w_next_bin  = {r_bcd[0], r_bin[BIN_W-1:1]};
    assign w_in_err    = |w_digit_bad;

    // Each nibble is corrected on its own, modulo 16, after the shift.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_nib;
            assign w_nib                 = w_shift_bcd[4*i +: 4];
            assign w_next_bcd[4*i +: 4]  = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
            assign w_digit_bad[i]        = (bcd_input[4*i +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bcd         <= '0;
            r_bin         <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            binary_output <= '0;
            err           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bcd    <= bcd_input;
                        r_bin    <= '0;
                        r_cnt    <= CNT_W'(BIN_W);
                        r_err    <= w_in_err;
                        in_ready <= 1'b0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_next_bcd;
                    r_bin <= w_next_bin;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Final iteration: publish the result directly from the next-value path.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state       <= S_DONE;
                        out_valid     <= 1'b1;
                        binary_output <= r_err ? '0 : w_next_bin;
                        err           <= r_err;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
